// File: rtl/ewb_coalesce.sv
// Eviction write buffer with write coalescing and a registered lookup port.
// Dirty victim lines queue FIFO-style and drain through a valid/yumi port.
// Repeat evictions to a queued line overwrite that entry in place, so each
// line tag has at most one live entry.
module ewb_coalesce #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 32,
    parameter int OFFSET = 5,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              ready_o,
    input  logic              lookup_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [WIDTH-1:0]  hit_data_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [WIDTH-1:0]  data_o,
    input  logic              yumi_i,
    output logic [PTR_W:0]    count_o
);

    localparam int TAG_W = ADDR_W - OFFSET;

    // Control state (reset) and entry storage (not reset)
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             hit_q, hit_d;
    logic [WIDTH-1:0] hit_data_q, hit_data_d;

    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] lk_tag;
    logic [DEPTH-1:0] enq_match;
    logic [DEPTH-1:0] lk_match;
    logic             deq;
    logic             full;
    logic             coalesce_match;
    logic             enq;
    logic             append;
    logic             bypass;
    logic [PTR_W-1:0] coal_idx;
    logic [WIDTH-1:0] lk_data;
    logic             mem_wr_en;
    logic [PTR_W-1:0] mem_wr_idx;

    // Offset bits of both addresses are don't-care by definition
    logic unused_offset_bits;
    assign unused_offset_bits = ^{addr_i[OFFSET-1:0], lookup_addr_i[OFFSET-1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_tag = addr_i[ADDR_W-1:OFFSET];
    assign lk_tag = lookup_addr_i[ADDR_W-1:OFFSET];

    assign valid_o = (count_q != '0);
    assign deq     = yumi_i & valid_o;
    assign full    = (count_q == (PTR_W+1)'(DEPTH));

    // Per-entry tag compares. A head leaving this cycle cannot absorb a write,
    // but it still answers a lookup since its data is valid before the edge.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign enq_match[gi] = valid_q[gi] && (tag_mem[gi] == in_tag) &&
                               !(deq && (rd_ptr_q == PTR_W'(gi)));
        assign lk_match[gi]  = valid_q[gi] && (tag_mem[gi] == lk_tag);
    end

    assign coalesce_match = |enq_match;
    assign ready_o        = !full | coalesce_match | yumi_i;
    assign enq            = valid_i & ready_o;
    assign append         = enq & !coalesce_match;
    assign bypass         = lookup_i & enq & (in_tag == lk_tag);

    // Encode the (at most one-hot) match vectors into an index and a data word
    always_comb begin
        coal_idx = '0;
        lk_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_match[i]) coal_idx = PTR_W'(i);
            if (lk_match[i])  lk_data  = lk_data | data_mem[i];
        end
    end

    // Next-state for pointers, occupancy, valid bits, lookup result and write port
    always_comb begin
        rd_ptr_d   = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = append ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        hit_d      = lookup_i & (bypass | (|lk_match));
        hit_data_d = hit_data_q;
        mem_wr_en  = enq;
        mem_wr_idx = coalesce_match ? coal_idx : wr_ptr_q;

        if (append && !deq) count_d = count_q + 1'b1;
        if (deq && !append) count_d = count_q - 1'b1;

        // Clear before set: when full, append and dequeue share the same slot
        if (deq)    valid_d[rd_ptr_q] = 1'b0;
        if (append) valid_d[wr_ptr_q] = 1'b1;

        // Newest data wins when the looked-up line is being written this cycle
        if (bypass)             hit_data_d = data_i;
        else if (lookup_i && |lk_match) hit_data_d = lk_data;
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            hit_q      <= 1'b0;
            hit_data_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            hit_data_q <= hit_data_d;
        end
    end

    // Entry storage: single write port, used for both append and coalesce
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            tag_mem[mem_wr_idx]  <= in_tag;
            data_mem[mem_wr_idx] <= data_i;
        end
    end

    assign hit_o      = hit_q;
    assign hit_data_o = hit_data_q;
    assign addr_o     = {tag_mem[rd_ptr_q], {OFFSET{1'b0}}};
    assign data_o     = data_mem[rd_ptr_q];
    assign count_o    = count_q;

    // Consumer must not take from an empty buffer
    a_yumi_when_valid: assert property (@(posedge clk) disable iff (!rst_n) yumi_i |-> valid_o)
        else $error("yumi_i asserted while valid_o=0");

endmodule

// File: tb/tb_ewb_coalesce.sv
// Testbench for ewb_coalesce: directed scenarios followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_ewb_coalesce;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         ready_o;
    logic         lookup_i = 1'b0;
    logic [31:0]  lookup_addr_i = '0;
    logic         hit_o;
    logic [255:0] hit_data_o;
    logic         valid_o;
    logic [31:0]  addr_o;
    logic [255:0] data_o;
    logic         yumi_i = 1'b0;
    logic [3:0]   count_o;

    ewb_coalesce dut (
        .clk(clk), .rst_n(rst_n),
        .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i), .ready_o(ready_o),
        .lookup_i(lookup_i), .lookup_addr_i(lookup_addr_i),
        .hit_o(hit_o), .hit_data_o(hit_data_o),
        .valid_o(valid_o), .addr_o(addr_o), .data_o(data_o),
        .yumi_i(yumi_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } ent_t;

    ent_t         mq[$];
    logic         exp_hit = 1'b0;
    logic [255:0] exp_hit_data = '0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    function automatic int find(input logic [26:0] t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [255:0] d,
                        input logic y, input logic lk, input logic [31:0] la);
        logic [26:0]  tg;
        logic [26:0]  ltg;
        int           idx;
        int           li;
        logic         deq;
        logic         coal;
        logic         rdy;
        logic         byp;
        logic         nh;
        logic [255:0] nd;
        @(negedge clk);
        deq = y && (mq.size() != 0);
        valid_i = v; addr_i = a; data_i = d; yumi_i = deq;
        lookup_i = lk; lookup_addr_i = la;
        #1;
        tg   = a[31:5];
        ltg  = la[31:5];
        idx  = find(tg);
        coal = (idx >= 0) && !(idx == 0 && deq);
        rdy  = (mq.size() < 8) || coal || deq;

        chk("ready", {255'd0, ready_o}, {255'd0, rdy});
        chk("valid", {255'd0, valid_o}, {255'd0, mq.size() != 0});
        chk("count", {252'd0, count_o}, 256'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_addr", {224'd0, addr_o}, {224'd0, mq[0].tag, 5'd0});
            chk("head_data", data_o, mq[0].data);
        end
        chk("hit", {255'd0, hit_o}, {255'd0, exp_hit});
        if (exp_hit) chk("hit_data", hit_data_o, exp_hit_data);

        li  = find(ltg);
        byp = lk && v && rdy && (ltg == tg);
        nh  = lk && (byp || li >= 0);
        nd  = byp ? d : ((lk && li >= 0) ? mq[li].data : exp_hit_data);

        if (v && rdy && coal) mq[idx].data = d;
        if (deq) void'(mq.pop_front());
        if (v && rdy && !coal) mq.push_back('{tag: tg, data: d});
        exp_hit      = nh;
        exp_hit_data = nd;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 256'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic enq(input logic [31:0] a, input logic [255:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mq.size() != 0; i++)
            step(1'b0, 32'h0, 256'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_i = 1'b0; yumi_i = 1'b0; lookup_i = 1'b0;
        #2;
        chk("rst_valid", {255'd0, valid_o}, 256'd0);
        chk("rst_hit", {255'd0, hit_o}, 256'd0);
        chk("rst_count", {252'd0, count_o}, 256'd0);
        chk("rst_ready", {255'd0, ready_o}, 256'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        exp_hit = 1'b0;
    endtask

    initial begin
        logic [255:0] da;
        logic [255:0] db;
        logic [255:0] dn;
        #3;
        do_reset();
        idle();

        // Two entries, drained in order
        da = rnd256(); db = rnd256();
        enq(32'h1000, da);
        enq(32'h2000, db);
        idle();
        chk("cnt_two", {252'd0, count_o}, 256'd2);
        chk("head_a", data_o, da);
        drain();
        idle();
        chk("empty_after", {255'd0, valid_o}, 256'd0);

        // Fill, then coalesce into a full buffer
        for (int i = 1; i <= 8; i++) enq(32'h1000 * i, rnd256());
        idle();
        chk("full_ready", {255'd0, ready_o}, 256'd0);
        dn = rnd256();
        enq(32'h3004, dn);
        idle();
        chk("coal_count", {252'd0, count_o}, 256'd8);
        drain();

        // Full with simultaneous append + dequeue, three wrap rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) enq(32'h1000 * (i + 1), rnd256());
            for (int i = 0; i < 8; i++)
                step(1'b1, 32'h10000 * (r + 1) + 32'h1000 * i, rnd256(), 1'b1, 1'b0, 32'h0);
            idle();
            chk("wrap_count", {252'd0, count_o}, 256'd8);
            drain();
        end

        // Lookup hit, miss, and bypass
        db = rnd256();
        enq(32'h2000, db);
        step(1'b0, 32'h0, 256'h0, 1'b0, 1'b1, 32'h2010);
        idle();
        chk("lk_hit_data", hit_data_o, db);
        step(1'b0, 32'h0, 256'h0, 1'b0, 1'b1, 32'h4000);
        dn = rnd256();
        step(1'b1, 32'h5000, dn, 1'b0, 1'b1, 32'h5000);
        idle();
        chk("lk_bypass", hit_data_o, dn);
        drain();

        // Head dequeued while the same tag is enqueued: appended, drains twice
        da = rnd256(); dn = rnd256();
        enq(32'h1000, da);
        enq(32'h2000, rnd256());
        step(1'b1, 32'h1000, dn, 1'b1, 1'b0, 32'h0);
        idle();
        chk("redeq_count", {252'd0, count_o}, 256'd2);
        drain();

        // Reset with contents and a lookup in flight
        for (int i = 1; i <= 5; i++) enq(32'h1000 * i, rnd256());
        step(1'b0, 32'h0, 256'h0, 1'b0, 1'b1, 32'h3000);
        @(posedge clk);
        #1;
        do_reset();
        idle();

        // Random traffic over a small tag set to provoke coalescing and hits
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0,
                 32'h1000 * $urandom_range(1, 12) + $urandom_range(0, 31),
                 rnd256(),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) != 0,
                 32'h1000 * $urandom_range(1, 12) + $urandom_range(0, 31));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
